// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation-side ioctl image loader.
package sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ARM,
    ST_WRITE,
    ST_GAP,
    ST_TAIL,
    ST_DONE
  } state_t;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Address increment per written word: 1 for byte images, 2 for 16-bit images.
  function automatic int unsigned ADDR_STEP(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sim_ioctl_loader_fifo.sv
// Synchronous show-ahead FIFO: o_data always presents the head word while not empty.
module sim_word_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sim_ioctl_loader.sv
// Clocked replay engine: drains host-pushed image words onto the core's ioctl bus
// with HPS-like pacing and ioctl_wait back-pressure.
module sim_ioctl_loader
  import sim_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 7,
  parameter int TAIL       = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        start_index,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [ADDR_W-1:0] img_len,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [DATA_W-1:0] ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underrun_cnt
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP(DATA_W));
  localparam logic [7:0]        GAP_LOAD  = 8'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [15:0]       TAIL_LOAD = 16'(TAIL - 1);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_index;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dout;
  logic [ADDR_W-1:0]   r_remain;
  logic [7:0]          r_gap_cnt;
  logic [15:0]         r_tail_cnt;
  logic [15:0]         r_underrun;
  logic                r_download;
  logic                r_wr;
  logic                r_busy;
  logic                r_done;
  logic                w_pop;
  logic                w_push;
  logic                w_underrun_inc;
  logic [ADDR_W-1:0]   w_remain_dec;
  logic [DATA_W-1:0]   w_fifo_data;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_fifo_count;

  sim_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (host_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign host_ready   = (w_fifo_count != CNT_W'(FIFO_DEPTH));
  assign w_push       = host_valid & ~w_fifo_full;
  assign w_remain_dec = r_remain - ADDR_W'(1);

  always_comb begin
    w_next         = r_state;
    w_pop          = 1'b0;
    w_underrun_inc = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_SETUP;
      ST_SETUP: w_next = (r_remain == '0) ? ST_TAIL : ST_ARM;
      ST_ARM: begin
        if (!ioctl_wait) begin
          if (!w_fifo_empty) begin
            w_pop  = 1'b1;
            w_next = ST_WRITE;
          end else begin
            w_underrun_inc = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (w_remain_dec == '0) w_next = ST_TAIL;
        else if (WR_GAP == 0)   w_next = ST_ARM;
        else                    w_next = ST_GAP;
      end
      ST_GAP:   if (r_gap_cnt == '0) w_next = ST_ARM;
      ST_TAIL:  if (r_tail_cnt == '0) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_download <= 1'b0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_index    <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_underrun <= '0;
    end else begin
      r_state    <= w_next;
      r_download <= (w_next inside {ST_SETUP, ST_ARM, ST_WRITE, ST_GAP, ST_TAIL});
      r_busy     <= (w_next inside {ST_SETUP, ST_ARM, ST_WRITE, ST_GAP, ST_TAIL});
      r_wr       <= (w_next == ST_WRITE);
      r_done     <= (w_next == ST_DONE);
      if (r_state == ST_IDLE && start) begin
        r_index <= start_index;
        r_addr  <= start_base;
      end
      if (w_pop) r_dout <= w_fifo_data;
      // The final write leaves the address on the last word written.
      if (r_state == ST_WRITE && w_remain_dec != '0) r_addr <= r_addr + STEP;
      if (w_underrun_inc && r_underrun != UNDERRUN_MAX) r_underrun <= r_underrun + 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (r_state == ST_IDLE && start) r_remain <= img_len;
    else if (r_state == ST_WRITE)    r_remain <= w_remain_dec;
    if (r_state == ST_WRITE)                  r_gap_cnt <= GAP_LOAD;
    else if (r_state == ST_GAP)               r_gap_cnt <= r_gap_cnt - 8'd1;
    if (w_next == ST_TAIL && r_state != ST_TAIL) r_tail_cnt <= TAIL_LOAD;
    else if (r_state == ST_TAIL)                 r_tail_cnt <= r_tail_cnt - 16'd1;
  end

  assign ioctl_download = r_download;
  assign ioctl_wr       = r_wr;
  assign ioctl_addr     = r_addr;
  assign ioctl_dout     = r_dout;
  assign ioctl_index    = r_index;
  assign busy           = r_busy;
  assign done           = r_done;
  assign underrun_cnt   = r_underrun;

endmodule
